core_clk_reset_ctrl: RTL and testbench
======================================

# core_clk_reset_ctrl

Sequences core reset and clock enables from the core PLL. It sits directly downstream of the core PLL: it runs on the 49.152 MHz system clock, consumes the PLL `locked` flag, and releases the game core from reset only after lock has been stable. It then generates the 6.144 MHz pixel and 3.072 MHz CPU clock-enable strobes. On loss of lock it re-asserts core reset immediately and re-runs the full sequence.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth for `pll_locked`; must be ≥2.
- `STABLE_CYCLES`, 1024: cycles `lock_s` must stay high before the hold phase; must be ≥2.
- `HOLD_CYCLES`, 64: cycles core reset is held after stabilisation or after soft reset; must be ≥2.
- `clk_sys` in 1: 49.152 MHz system clock (PLL outclk_0); the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL lock flag, asynchronous to `clk_sys`.
- `soft_reset` in 1: synchronous, level-sensitive core restart request.
- `pause` in 1: synchronous; freezes the enable divider.
- `core_reset` out 1: active-high core reset, registered.
- `ce_6m` out 1: one-cycle strobe every 8 cycles, registered.
- `ce_3m` out 1: one-cycle strobe every 16 cycles, coincident with every second `ce_6m`, registered.
- `running` out 1: high in RUN state.
- `lock_lost_count` out 8: number of lock losses seen in RUN; saturates at 255.

## Operation
- `pll_locked` passes through a `SYNC_STAGES` flop chain and becomes `lock_s`. The chain resets to 0.
- The state machine has four states: WAIT_LOCK, STABILIZE, HOLD, RUN. The reset state is WAIT_LOCK.
- WAIT_LOCK:
  - `core_reset`=1.
  - Stable and hold counters are cleared.
  - `lock_s`=1 → STABILIZE.
- STABILIZE:
  - The stable counter increments each cycle.
  - `lock_s`=0 → WAIT_LOCK and the counter is cleared.
  - When the counter reaches `STABLE_CYCLES`-1 → HOLD.
- HOLD:
  - The hold counter increments while `soft_reset`=0 and is held at 0 while `soft_reset`=1.
  - When the counter reaches `HOLD_CYCLES`-1 with `soft_reset`=0 → RUN.
  - `lock_s`=0 → WAIT_LOCK.
- RUN:
  - `core_reset`=0 and `running`=1.
  - `lock_s`=0 → WAIT_LOCK and `lock_lost_count`+1 (saturating).
  - Otherwise `soft_reset`=1 → HOLD with the hold counter cleared.
  - Lock loss has priority over `soft_reset`.
- `core_reset` is a registered decode: it is 1 in every state except RUN.
- Divider:
  - A 4-bit counter `div` is 0 in every non-RUN state.
  - In RUN it increments mod 16 when `pause`=0 and holds its value when `pause`=1.
  - Next-state enable logic: `ce_6m` is set when RUN, `pause`=0 and `div[2:0]`=7.
  - `ce_3m` is set under the same conditions with `div`=15.
  - Both enables are 0 outside RUN.
- Counter widths are `$clog2` of the respective parameter. No counter wraps; each is bounded by its terminal compare.

## Timing
- Reset values:
  - `core_reset`=1.
  - `ce_6m`=0, `ce_3m`=0, `running`=0.
  - `lock_lost_count`=0.
  - `div`=0.
- `reset_n` asserted mid-operation forces all reset values asynchronously. Release is sampled on the next `clk_sys` edge.
- Lock-up latency:
  - Let edge 0 be the first edge at which `pll_locked`=1 is sampled.
  - `core_reset` falls after edge `SYNC_STAGES`+`STABLE_CYCLES`+`HOLD_CYCLES`, provided lock and `soft_reset`=0 are held throughout.
- Enable timing after release:
  - The first `ce_6m` is high on the 8th cycle after `core_reset` falls.
  - The first `ce_3m` is high on the 16th cycle after `core_reset` falls.
- Lock loss:
  - `pll_locked` falling reaches `lock_s` after `SYNC_STAGES` edges.
  - `core_reset`=1 and both enables go 0 on the next edge.
  - A `lock_s` glitch shorter than one cycle after synchronisation is still treated as a loss.
- Soft reset in RUN: `core_reset`=1 one edge after `soft_reset` is sampled high. The hold phase restarts on `soft_reset` falling.
- `pause`: enables go low one edge after `pause` is sampled high. The divider phase is preserved across the pause.

## Test plan
Parameters for all scenarios: `SYNC_STAGES`=2, `STABLE_CYCLES`=16, `HOLD_CYCLES`=8.
- Clean lock: release `reset_n`, raise `pll_locked` at edge 0 → `core_reset` falls after edge 26. `ce_6m` pulses every 8 cycles starting 8 cycles later. `ce_3m` pulses every 16 cycles, aligned to every other `ce_6m`.
- Unstable lock: drop `pll_locked` for 3 cycles at edge 10 (during STABILIZE) → `core_reset` stays 1. The full 16+8 sequence restarts from the re-lock, and `lock_lost_count` stays 0.
- Lock loss in RUN: drop `pll_locked` → `core_reset`=1 and enables 0 exactly 3 edges later, `lock_lost_count`=1. Re-lock → release again after 26 edges.
- Soft reset: hold `soft_reset` high for 5 cycles in RUN → `core_reset` high 1 edge later. `core_reset` falls 8 cycles after `soft_reset` drops, and the divider restarts at 0.
- Pause: assert `pause` for 20 cycles with `div`=5 → no strobes during the pause. After release, the next `ce_6m` arrives 3 cycles later.
- Saturation and simultaneous events: cycle lock loss 300 times → `lock_lost_count`=255. Asserting `soft_reset` and lock loss in the same cycle → state goes to WAIT_LOCK and the count increments.

Source files
------------

// File: rtl/core_clk_reset_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_clk_reset_ctrl: PLL-lock gated core reset sequencer with 6M/3M CEs   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module core_clk_reset_ctrl #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 1024,
   parameter int HOLD_CYCLES   = 64
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       pll_locked,
   input  logic       soft_reset,
   input  logic       pause,
   output logic       core_reset,
   output logic       ce_6m,
   output logic       ce_3m,
   output logic       running,
   output logic [7:0] lock_lost_count
);

   localparam int C_STABLE_W = $clog2(STABLE_CYCLES);
   localparam int C_HOLD_W   = $clog2(HOLD_CYCLES);
   localparam logic [C_STABLE_W-1:0] C_STABLE_LAST = C_STABLE_W'(STABLE_CYCLES - 1);
   localparam logic [C_HOLD_W-1:0]   C_HOLD_LAST   = C_HOLD_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_STABILIZE = 2'd1,
      ST_HOLD      = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   lock_s;
   state_t                 state_q, state_d;
   logic [C_STABLE_W-1:0]  stable_q, stable_d;
   logic [C_HOLD_W-1:0]    hold_q, hold_d;
   logic [3:0]             div_q, div_d;
   logic [7:0]             lost_q, lost_d;
   logic                   core_reset_q, core_reset_d;
   logic                   ce_6m_q, ce_6m_d;
   logic                   ce_3m_q, ce_3m_d;
   logic                   running_q, running_d;
   logic                   run_stay;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], pll_locked};
   assign lock_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d  = state_q;
      stable_d = stable_q;
      hold_d   = hold_q;
      lost_d   = lost_q;
      case (state_q)
         ST_WAIT_LOCK: begin
            stable_d = '0;
            hold_d   = '0;
            if (lock_s) state_d = ST_STABILIZE;
         end
         ST_STABILIZE: begin
            if (!lock_s) begin
               state_d  = ST_WAIT_LOCK;
               stable_d = '0;
            end else if (stable_q == C_STABLE_LAST) begin
               state_d  = ST_HOLD;
               stable_d = '0;
               hold_d   = '0;
            end else begin
               stable_d = stable_q + C_STABLE_W'(1);
            end
         end
         ST_HOLD: begin
            if (!lock_s) begin
               state_d = ST_WAIT_LOCK;
               hold_d  = '0;
            end else if (soft_reset) begin
               hold_d = '0;
            end else if (hold_q == C_HOLD_LAST) begin
               state_d = ST_RUN;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + C_HOLD_W'(1);
            end
         end
         ST_RUN: begin
            // Lock loss outranks a simultaneous soft reset.
            if (!lock_s) begin
               state_d = ST_WAIT_LOCK;
               if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
            end else if (soft_reset) begin
               state_d = ST_HOLD;
               hold_d  = '0;
            end
         end
         default: state_d = ST_WAIT_LOCK;
      endcase
   end

   always_comb begin
      // The divider only advances while RUN is both current and next, so it
      // restarts from 0 on every entry into RUN and strobes stop on exit.
      run_stay     = (state_q == ST_RUN) && (state_d == ST_RUN);
      div_d        = 4'd0;
      ce_6m_d      = 1'b0;
      ce_3m_d      = 1'b0;
      core_reset_d = (state_d != ST_RUN);
      running_d    = (state_d == ST_RUN);
      if (run_stay) begin
         if (pause) begin
            div_d = div_q;
         end else begin
            div_d   = div_q + 4'd1;
            ce_6m_d = (div_q[2:0] == 3'd7);
            ce_3m_d = (div_q == 4'd15);
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sync_q       <= '0;
         state_q      <= ST_WAIT_LOCK;
         stable_q     <= '0;
         hold_q       <= '0;
         div_q        <= 4'd0;
         lost_q       <= 8'd0;
         core_reset_q <= 1'b1;
         ce_6m_q      <= 1'b0;
         ce_3m_q      <= 1'b0;
         running_q    <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         state_q      <= state_d;
         stable_q     <= stable_d;
         hold_q       <= hold_d;
         div_q        <= div_d;
         lost_q       <= lost_d;
         core_reset_q <= core_reset_d;
         ce_6m_q      <= ce_6m_d;
         ce_3m_q      <= ce_3m_d;
         running_q    <= running_d;
      end
   end

   assign core_reset      = core_reset_q;
   assign ce_6m           = ce_6m_q;
   assign ce_3m           = ce_3m_q;
   assign running         = running_q;
   assign lock_lost_count = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_core_clk_reset_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_core_clk_reset_ctrl: directed + random bench with lock-sequence model |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_core_clk_reset_ctrl;

   localparam int SYNC   = 2;
   localparam int STABLE = 16;
   localparam int HOLD   = 8;

   logic       clk_sys;
   logic       reset_n;
   logic       pll_locked;
   logic       soft_reset;
   logic       pause;
   logic       core_reset;
   logic       ce_6m;
   logic       ce_3m;
   logic       running;
   logic [7:0] lock_lost_count;

   int n_vec = 0;
   int n_err = 0;

   core_clk_reset_ctrl #(
      .SYNC_STAGES   (SYNC),
      .STABLE_CYCLES (STABLE),
      .HOLD_CYCLES   (HOLD)
   ) dut (
      .clk_sys         (clk_sys),
      .reset_n         (reset_n),
      .pll_locked      (pll_locked),
      .soft_reset      (soft_reset),
      .pause           (pause),
      .core_reset      (core_reset),
      .ce_6m           (ce_6m),
      .ce_3m           (ce_3m),
      .running         (running),
      .lock_lost_count (lock_lost_count)
   );

   initial clk_sys = 1'b0;
   always #10 clk_sys = ~clk_sys;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d required %0d", name, $time, act, exp);
      end
   endtask

   // Model: lock_s seen at an edge is pll_locked sampled SYNC edges earlier;
   // m_need counts edges left until release (-1 = waiting for lock), and
   // m_elapsed counts unpaused RUN cycles since release.
   bit lq[$];
   bit seen;
   bit m_run;
   bit prev_run;
   int m_need;
   int m_lost;
   int m_elapsed;
   bit exp_ce6;
   bit exp_ce3;

   task automatic model_reset();
      lq.delete();
      for (int i = 0; i < SYNC; i++) lq.push_back(1'b0);
      m_run     = 1'b0;
      m_need    = -1;
      m_lost    = 0;
      m_elapsed = 0;
      exp_ce6   = 1'b0;
      exp_ce3   = 1'b0;
   endtask

   always @(posedge clk_sys) begin
      if (!reset_n) begin
         model_reset();
      end else begin
         seen = lq.pop_front();
         lq.push_back(pll_locked);
         prev_run = m_run;
         if (m_run) begin
            if (!seen) begin
               m_run  = 1'b0;
               m_need = -1;
               if (m_lost < 255) m_lost++;
            end else if (soft_reset) begin
               m_run  = 1'b0;
               m_need = HOLD;
            end
         end else if (!seen) begin
            m_need = -1;
         end else if (m_need < 0) begin
            m_need = STABLE + HOLD;
         end else if (soft_reset && m_need <= HOLD) begin
            m_need = HOLD;
         end else begin
            m_need--;
            if (m_need == 0) begin
               m_run     = 1'b1;
               m_elapsed = 0;
            end
         end
         exp_ce6 = prev_run && m_run && !pause && (m_elapsed % 8 == 7);
         exp_ce3 = prev_run && m_run && !pause && (m_elapsed % 16 == 15);
         if (prev_run && m_run && !pause) m_elapsed++;
      end
      #1;
      chk("core_reset", core_reset, !m_run);
      chk("running", running, m_run);
      chk("ce_6m", ce_6m, exp_ce6);
      chk("ce_3m", ce_3m, exp_ce3);
      chk("lock_lost_count", lock_lost_count, m_lost);
   end

   // sel: 0 core_reset, 1 ce_6m, 2 ce_3m; k = negedges waited
   task automatic count_until(input int sel, input logic val, input int limit, output int k);
      logic s;
      k = 0;
      do begin
         @(negedge clk_sys);
         k++;
         s = (sel == 0) ? core_reset : (sel == 1) ? ce_6m : ce_3m;
      end while (s != val && k < limit);
      if (s != val) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_timeout sel=%0d: got %0d required %0d after %0d cycles", sel, s, val, k);
      end
   endtask

   initial begin
      int k;
      int strobes;
      reset_n    = 1'b0;
      pll_locked = 1'b0;
      soft_reset = 1'b0;
      pause      = 1'b0;
      repeat (3) @(negedge clk_sys);
      chk("reset_core_reset", core_reset, 1);
      chk("reset_lost", lock_lost_count, 0);
      reset_n = 1'b1;
      @(negedge clk_sys);

      // Clean lock: first sampling edge is edge 0
      pll_locked = 1'b1;
      count_until(0, 1'b0, 200, k);
      chk("lockup_edge", k - 1, SYNC + STABLE + HOLD);
      count_until(1, 1'b1, 40, k);
      chk("first_ce6m", k, 8);
      count_until(2, 1'b1, 40, k);
      chk("first_ce3m_after_ce6m", k, 8);
      chk("ce3m_with_ce6m", ce_6m, 1);

      // Pause with div = 5
      repeat (5) @(negedge clk_sys);
      pause   = 1'b1;
      strobes = 0;
      repeat (20) begin
         @(negedge clk_sys);
         strobes += int'(ce_6m) + int'(ce_3m);
      end
      chk("pause_strobes", strobes, 0);
      pause = 1'b0;
      count_until(1, 1'b1, 20, k);
      chk("pause_resume_ce6m", k, 3);

      // Soft reset held 5 cycles
      soft_reset = 1'b1;
      @(negedge clk_sys);
      chk("soft_assert", core_reset, 1);
      repeat (4) @(negedge clk_sys);
      soft_reset = 1'b0;
      count_until(0, 1'b0, 40, k);
      chk("soft_release", k, 8);
      count_until(1, 1'b1, 20, k);
      chk("soft_div_restart", k, 8);

      // Lock loss in RUN
      pll_locked = 1'b0;
      count_until(0, 1'b1, 10, k);
      chk("lockloss_edges", k, 3);
      chk("lockloss_count", lock_lost_count, 1);
      pll_locked = 1'b1;
      count_until(0, 1'b0, 100, k);
      chk("relock_edge", k - 1, 26);

      // Lock loss and soft reset reach the FSM on the same edge
      pll_locked = 1'b0;
      repeat (2) @(negedge clk_sys);
      soft_reset = 1'b1;
      @(negedge clk_sys);
      chk("simul_core_reset", core_reset, 1);
      chk("simul_count", lock_lost_count, 2);
      soft_reset = 1'b0;
      repeat (4) @(negedge clk_sys);

      // Unstable lock: 3-cycle dropout at edge 10
      pll_locked = 1'b1;
      repeat (10) @(negedge clk_sys);
      pll_locked = 1'b0;
      repeat (3) @(negedge clk_sys);
      pll_locked = 1'b1;
      count_until(0, 1'b0, 100, k);
      chk("unstable_edge", 12 + k, 39);
      chk("unstable_count", lock_lost_count, 2);

      // Saturation
      repeat (300) begin
         pll_locked = 1'b0;
         repeat (4) @(negedge clk_sys);
         pll_locked = 1'b1;
         count_until(0, 1'b0, 60, k);
      end
      chk("saturate", lock_lost_count, 255);

      // Asynchronous reset mid-operation
      reset_n = 1'b0;
      #1;
      chk("async_core_reset", core_reset, 1);
      chk("async_running", running, 0);
      chk("async_lost", lock_lost_count, 0);
      @(negedge clk_sys);
      reset_n = 1'b1;

      // Randomised traffic
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk_sys);
         reset_n = ($urandom_range(0, 1499) != 0);
         if (pll_locked) pll_locked = ($urandom_range(0, 149) != 0);
         else            pll_locked = ($urandom_range(0, 3) == 0);
         if (soft_reset) soft_reset = ($urandom_range(0, 2) != 0);
         else            soft_reset = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 19) == 0) pause = ~pause;
      end
      @(negedge clk_sys);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
